// File: rtl/ahb_pkg.sv
// Shared AHB arbiter types: transfer/burst encodings, master count and the
// beat-counter load value for each burst type.
package ahb_pkg;

  localparam int NUM_MASTERS  = 4;
  localparam int MASTER_IDX_W = 2;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_e;

  // Beats remaining after the NONSEQ beat; zero for undefined-length bursts.
  function automatic logic [3:0] burst_len(input hburst_e burst);
    case (burst)
      HBURST_WRAP4,  HBURST_INCR4:  burst_len = 4'd3;
      HBURST_WRAP8,  HBURST_INCR8:  burst_len = 4'd7;
      HBURST_WRAP16, HBURST_INCR16: burst_len = 4'd15;
      default:                      burst_len = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_arb_picker.sv
// Combinational winner selection. Round-robin from ptr_i+1 by default;
// fixed priority (master 0 highest) when AHB_ARB_FIXED_PRIO_EN is defined.
module ahb_arb_picker
  import ahb_pkg::*;
#(
  parameter logic [MASTER_IDX_W-1:0] DEF_IDX = '0
) (
  input  logic [NUM_MASTERS-1:0]  req_i,
`ifndef AHB_ARB_FIXED_PRIO_EN
  input  logic [MASTER_IDX_W-1:0] ptr_i,
`endif
  output logic [MASTER_IDX_W-1:0] winner_o
);

`ifdef AHB_ARB_FIXED_PRIO_EN
  always_comb begin
    winner_o = DEF_IDX;
    // Scan downwards so the lowest requesting index is the last one written.
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (req_i[i]) winner_o = i[MASTER_IDX_W-1:0];
    end
  end
`else
  logic [MASTER_IDX_W-1:0] idx;
  logic                    found;

  always_comb begin
    winner_o = DEF_IDX;
    found    = 1'b0;
    idx      = '0;
    // The pointer itself is visited last, giving the current owner lowest priority.
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      idx = ptr_i + MASTER_IDX_W'(i);
      if (!found && req_i[idx]) begin
        winner_o = idx;
        found    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/ahb_arbiter.sv
// 4-master AHB bus arbiter: round-robin grant with burst/lock protection and
// default-master parking. AHB_ARB_FIXED_PRIO_EN selects fixed-priority winners.
module ahb_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                            HCLK,
  input  logic                            HRST,
  input  logic [NUM_MASTERS-1:0]          HBUSREQ,
  input  logic [NUM_MASTERS-1:0]          HLOCK,
  input  logic [1:0]                      HTRANS,
  input  logic [2:0]                      HBURST,
  input  logic                            HREADY,
  output logic [NUM_MASTERS-1:0]          HGRANT,
  output logic [ahb_pkg::MASTER_IDX_W-1:0] HMASTER,
  output logic                            HMASTLOCK
);
  import ahb_pkg::*;

  localparam logic [MASTER_IDX_W-1:0] DEF_IDX   = MASTER_IDX_W'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0]  DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

  htrans_e                 htrans;
  hburst_e                 hburst;
  logic [NUM_MASTERS-1:0]  grant_q, grant_d;
  logic [MASTER_IDX_W-1:0] hmaster_q, hmaster_d;
  logic                    mastlock_q, mastlock_d;
  logic                    lock_tail_q, lock_tail_d;
  logic [3:0]              beat_cnt_q, beat_cnt_d;
  logic [MASTER_IDX_W-1:0] grant_idx, winner;
  logic                    lock_req, arb_point, arb_ok;
`ifndef AHB_ARB_FIXED_PRIO_EN
  logic [MASTER_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
`endif

  ahb_arb_picker #(.DEF_IDX(DEF_IDX)) u_picker (
    .req_i    (HBUSREQ),
`ifndef AHB_ARB_FIXED_PRIO_EN
    .ptr_i    (rr_ptr_q),
`endif
    .winner_o (winner)
  );

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch can be inferred.
    htrans      = htrans_e'(HTRANS);
    hburst      = hburst_e'(HBURST);
    grant_idx   = '0;
    arb_point   = 1'b0;
    beat_cnt_d  = beat_cnt_q;
    grant_d     = grant_q;
`ifndef AHB_ARB_FIXED_PRIO_EN
    rr_ptr_d    = rr_ptr_q;
`endif

    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) grant_idx = i[MASTER_IDX_W-1:0];
    end
    lock_req = HLOCK[grant_idx];

    case (htrans)
      HTRANS_IDLE: begin
        arb_point  = 1'b1;
        beat_cnt_d = '0;
      end
      HTRANS_NONSEQ: begin
        arb_point  = (hburst == HBURST_SINGLE) || (hburst == HBURST_INCR);
        beat_cnt_d = burst_len(hburst);
      end
      HTRANS_SEQ: begin
        arb_point = (beat_cnt_q == 4'd1) || (hburst == HBURST_INCR);
        if (beat_cnt_q != 4'd0) beat_cnt_d = beat_cnt_q - 4'd1;
      end
      default: ;
    endcase

    arb_ok = !mastlock_q && !lock_tail_q && arb_point;

    // A lock request from the granted master overrides a pending handover.
    if (arb_ok && !lock_req) begin
      grant_d         = '0;
      grant_d[winner] = 1'b1;
`ifndef AHB_ARB_FIXED_PRIO_EN
      rr_ptr_d        = winner;
`endif
    end

    hmaster_d   = grant_idx;
    mastlock_d  = lock_req;
    lock_tail_d = mastlock_q && !lock_req;
  end

  always_ff @(posedge HCLK or posedge HRST) begin
    if (HRST) begin
      grant_q     <= DEF_GRANT;
      hmaster_q   <= DEF_IDX;
      mastlock_q  <= 1'b0;
      lock_tail_q <= 1'b0;
      beat_cnt_q  <= '0;
`ifndef AHB_ARB_FIXED_PRIO_EN
      rr_ptr_q    <= DEF_IDX;
`endif
    end else if (HREADY) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      grant_q     <= grant_d;
      hmaster_q   <= hmaster_d;
      mastlock_q  <= mastlock_d;
      lock_tail_q <= lock_tail_d;
      beat_cnt_q  <= beat_cnt_d;
`ifndef AHB_ARB_FIXED_PRIO_EN
      rr_ptr_q    <= rr_ptr_d;
`endif
    end
  end

  assign HGRANT    = grant_q;
  assign HMASTER   = hmaster_q;
  assign HMASTLOCK = mastlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed self-checking bench for ahb_arbiter: reset, round-robin order,
// burst protection with wait states, locked sequences and mid-burst reset.
module tb_ahb_arbiter;

  localparam logic [1:0] T_IDLE   = 2'd0;
  localparam logic [1:0] T_NONSEQ = 2'd2;
  localparam logic [1:0] T_SEQ    = 2'd3;
  localparam logic [2:0] B_SINGLE = 3'd0;
  localparam logic [2:0] B_INCR8  = 3'd5;
  localparam logic [2:0] B_INCR16 = 3'd7;

  logic       HCLK;
  logic       HRST;
  logic [3:0] HBUSREQ;
  logic [3:0] HLOCK;
  logic [1:0] HTRANS;
  logic [2:0] HBURST;
  logic       HREADY;
  logic [3:0] HGRANT;
  logic [1:0] HMASTER;
  logic       HMASTLOCK;

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] rr_grant [5];
  logic [1:0] rr_owner [5];

  ahb_arbiter #(.NUM_MASTERS(4), .DEFAULT_MASTER(0)) dut (
    .HCLK      (HCLK),
    .HRST      (HRST),
    .HBUSREQ   (HBUSREQ),
    .HLOCK     (HLOCK),
    .HTRANS    (HTRANS),
    .HBURST    (HBURST),
    .HREADY    (HREADY),
    .HGRANT    (HGRANT),
    .HMASTER   (HMASTER),
    .HMASTLOCK (HMASTLOCK)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive(input logic [3:0] req, input logic [3:0] lck,
                       input logic [1:0] tr, input logic [2:0] bu);
    HBUSREQ = req;
    HLOCK   = lck;
    HTRANS  = tr;
    HBURST  = bu;
  endtask

  task automatic do_reset();
    @(posedge HCLK);
    #1;
    HRST   = 1'b1;
    HREADY = 1'b1;
    drive(4'b0000, 4'b0000, T_IDLE, B_SINGLE);
    #1;
    check("rst_grant", HGRANT, 4'b0001);
    check("rst_owner", HMASTER, 2'd0);
    check("rst_lock", HMASTLOCK, 1'b0);
    #3;
    HRST = 1'b0;
    step();
  endtask

  task automatic run_incr8(input int waits);
    do_reset();
    drive(4'b0100, 4'b0000, T_IDLE, B_SINGLE);
    step();
    check("i8_grant_m2", HGRANT, 4'b0100);
    step();
    check("i8_owner_m2", HMASTER, 2'd2);
    for (int b = 0; b < 8; b++) begin
      drive((b == 7) ? 4'b1000 : 4'b1100, 4'b0000, (b == 0) ? T_NONSEQ : T_SEQ, B_INCR8);
      if (b == 4) begin
        for (int w = 0; w < waits; w++) begin
          HREADY = 1'b0;
          step();
          check("i8_wait_hold", HGRANT, 4'b0100);
        end
      end
      HREADY = 1'b1;
      step();
      if (b == 7) check("i8_handover", HGRANT, 4'b1000);
      else        check("i8_beat_hold", HGRANT, 4'b0100);
    end
    drive(4'b1000, 4'b0000, T_IDLE, B_SINGLE);
    check("i8_owner_still_m2", HMASTER, 2'd2);
    step();
    check("i8_owner_m3", HMASTER, 2'd3);
    check("i8_grant_kept_m3", HGRANT, 4'b1000);
  endtask

  initial begin
    HRST   = 1'b1;
    HREADY = 1'b1;
    drive(4'b0000, 4'b0000, T_IDLE, B_SINGLE);
    rr_grant = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    rr_owner = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    // Parking with no requests.
    do_reset();
    for (int c = 0; c < 4; c++) begin
      step();
      check("park_grant", HGRANT, 4'b0001);
      check("park_owner", HMASTER, 2'd0);
      check("park_lock", HMASTLOCK, 1'b0);
    end

    // Round-robin over SINGLE transfers with all masters requesting.
    do_reset();
    drive(4'b1111, 4'b0000, T_NONSEQ, B_SINGLE);
    for (int k = 0; k < 5; k++) begin
      step();
      check("rr_grant", HGRANT, rr_grant[k]);
      check("rr_owner", HMASTER, rr_owner[k]);
    end

    // INCR8 burst protection, without and with three wait states.
    run_incr8(0);
    run_incr8(3);

    // Locked sequence by M1 while M0 requests.
    do_reset();
    drive(4'b0011, 4'b0010, T_IDLE, B_SINGLE);
    step();
    check("lk_grant_m1", HGRANT, 4'b0010);
    step();
    check("lk_no_regrant", HGRANT, 4'b0010);
    check("lk_owner_m1", HMASTER, 2'd1);
    check("lk_mastlock_1", HMASTLOCK, 1'b1);
    for (int k = 0; k < 3; k++) begin
      drive(4'b0011, 4'b0010, T_NONSEQ, B_SINGLE);
      step();
      check("lk_mastlock_on", HMASTLOCK, 1'b1);
      check("lk_grant_held", HGRANT, 4'b0010);
    end
    drive(4'b0011, 4'b0000, T_NONSEQ, B_SINGLE);
    step();
    check("lk_mastlock_off", HMASTLOCK, 1'b0);
    check("lk_grant_lastlocked", HGRANT, 4'b0010);
    drive(4'b0011, 4'b0000, T_IDLE, B_SINGLE);
    step();
    check("lk_tail_block", HGRANT, 4'b0010);
    step();
    check("lk_grant_m0", HGRANT, 4'b0001);

    // Reset asserted during beat 5 of an INCR16 by M3.
    do_reset();
    drive(4'b1000, 4'b0000, T_IDLE, B_SINGLE);
    step();
    check("r16_grant_m3", HGRANT, 4'b1000);
    step();
    check("r16_owner_m3", HMASTER, 2'd3);
    drive(4'b1000, 4'b0000, T_NONSEQ, B_INCR16);
    step();
    for (int k = 0; k < 3; k++) begin
      drive(4'b1000, 4'b0000, T_SEQ, B_INCR16);
      step();
    end
    check("r16_pre_grant", HGRANT, 4'b1000);
    #2;
    HRST = 1'b1;
    #1;
    check("r16_rst_grant", HGRANT, 4'b0001);
    check("r16_rst_owner", HMASTER, 2'd0);
    check("r16_rst_lock", HMASTLOCK, 1'b0);
    #3;
    HRST = 1'b0;
    drive(4'b0000, 4'b0000, T_IDLE, B_SINGLE);
    step();

    // Two requesters M1 and M3 held.
    do_reset();
    drive(4'b1010, 4'b0000, T_NONSEQ, B_SINGLE);
    for (int k = 0; k < 6; k++) begin
      step();
`ifdef AHB_ARB_FIXED_PRIO_EN
      check("fp_grant_m1", HGRANT, 4'b0010);
`else
      if (k % 2 == 0) check("rr2_grant_m1", HGRANT, 4'b0010);
      else            check("rr2_grant_m3", HGRANT, 4'b1000);
`endif
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
